// File: rtl/spi_ram_responder.sv
// SPI mode-0 responder serving a 32 x 24-bit register RAM.
// sck/csn/si are oversampled in the clk domain; local port preloads/inspects.
module spi_ram_responder #(
  parameter int DATA_W      = 24,
  parameter int ADDR_W      = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              csn,
  input  logic              si,
  output logic              so,
  output logic              so_oe,
  input  logic              lw_en,
  input  logic [ADDR_W-1:0] lw_addr,
  input  logic [DATA_W-1:0] lw_data,
  output logic [DATA_W-1:0] lr_data,
  output logic              frame_done,
  output logic              frame_wr,
  output logic              frame_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(DATA_W > 8 ? DATA_W : 8);

  typedef enum logic [2:0] {
    IDLE, CMD, WDATA, RDATA, DONE
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync, csn_sync, si_sync;
  logic sck_q, csn_q;
  logic sck_s, csn_s, si_s;
  logic sck_rise, sck_fall, csn_rise, csn_fall;

  state_t state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [6:0]        cmd_sr, cmd_sr_d;
  logic [7:0]        cmd_d;
  logic [DATA_W-2:0] rx_sr, rx_d;
  logic [DATA_W-1:0] tx_sr, tx_d;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] addr, addr_d;
  logic oe_d, done_d, wr_d, err_d, we;

  logic [DATA_W-1:0] ram [0:DEPTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync <= '0;
      csn_sync <= '0;
      si_sync  <= '0;
      sck_q    <= 1'b0;
      csn_q    <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
      csn_sync <= {csn_sync[SYNC_STAGES-2:0], csn};
      si_sync  <= {si_sync[SYNC_STAGES-2:0], si};
      sck_q    <= sck_sync[SYNC_STAGES-1];
      csn_q    <= csn_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign csn_s    = csn_sync[SYNC_STAGES-1];
  assign si_s     = si_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_q;
  assign sck_fall = ~sck_s & sck_q;
  assign csn_rise = csn_s & ~csn_q;
  assign csn_fall = ~csn_s & csn_q;

  assign wdata = {rx_sr, si_s};
  assign so    = so_oe & tx_sr[DATA_W-1];

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    cmd_d    = {cmd_sr, si_s};
    cmd_sr_d = cmd_sr;
    rx_d     = rx_sr;
    tx_d     = tx_sr;
    addr_d   = addr;
    oe_d     = so_oe;
    done_d   = 1'b0;
    wr_d     = 1'b0;
    err_d    = 1'b0;
    we       = 1'b0;
    unique case (state)
      IDLE: begin
        if (csn_fall) begin
          state_d  = CMD;
          cnt_d    = '0;
          cmd_sr_d = '0;
          rx_d     = '0;
          tx_d     = '0;
        end
      end
      CMD: begin
        if (csn_rise) begin
          err_d   = 1'b1;
          oe_d    = 1'b0;
          state_d = IDLE;
        end else if (sck_rise) begin
          cmd_sr_d = cmd_d[6:0];
          cnt_d    = cnt + CNT_W'(1);
          if (cnt == CNT_W'(7)) begin
            cnt_d  = '0;
            addr_d = cmd_d[ADDR_W-1:0];
            if (cmd_d[7]) begin
              state_d = WDATA;
            end else begin
              tx_d    = ram[addr_d];
              oe_d    = 1'b1;
              state_d = RDATA;
            end
          end
        end
      end
      WDATA: begin
        if (csn_rise) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (sck_rise) begin
          rx_d  = wdata[DATA_W-2:0];
          cnt_d = cnt + CNT_W'(1);
          if (cnt == CNT_W'(DATA_W-1)) begin
            we      = 1'b1;
            done_d  = 1'b1;
            wr_d    = 1'b1;
            state_d = DONE;
          end
        end
      end
      RDATA: begin
        if (csn_rise) begin
          err_d   = 1'b1;
          oe_d    = 1'b0;
          state_d = IDLE;
        end else if (sck_rise) begin
          cnt_d = cnt + CNT_W'(1);
          if (cnt == CNT_W'(DATA_W-1)) begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end else if (sck_fall && cnt != '0) begin
          // MSB is preloaded; only falls after a data rise advance
          tx_d = {tx_sr[DATA_W-2:0], 1'b0};
        end
      end
      DONE: begin
        if (csn_rise) begin
          oe_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cmd_sr     <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      addr       <= '0;
      so_oe      <= 1'b0;
      frame_done <= 1'b0;
      frame_wr   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      cmd_sr     <= cmd_sr_d;
      rx_sr      <= rx_d;
      tx_sr      <= tx_d;
      addr       <= addr_d;
      so_oe      <= oe_d;
      frame_done <= done_d;
      frame_wr   <= wr_d;
      frame_err  <= err_d;
    end
  end

  // SPI commit wins a same-address collision with the local port
  always_ff @(posedge clk) begin
    if (lw_en && !(we && lw_addr == addr))
      ram[lw_addr] <= lw_data;
    if (we)
      ram[addr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lr_data <= '0;
    else     lr_data <= ram[lw_addr];
  end

endmodule

// File: tb/tb_spi_ram_responder.sv
// Bench for spi_ram_responder: bit-banged SPI master plus
// a word-level RAM model with frame semantics.
module tb_spi_ram_responder;

  logic        clk = 1'b0;
  logic        rst, sck, csn, si;
  logic        so, so_oe;
  logic        lw_en;
  logic [4:0]  lw_addr;
  logic [23:0] lw_data, lr_data;
  logic        frame_done, frame_wr, frame_err;

  logic [23:0] ref_ram [32];
  int          vectors = 0;
  int          miscompares = 0;
  int          dcnt, ecnt;
  logic        last_wr;
  logic [23:0] rx;

  always #5 clk = ~clk;

  spi_ram_responder dut (
    .clk(clk), .rst(rst), .sck(sck), .csn(csn), .si(si),
    .so(so), .so_oe(so_oe), .lw_en(lw_en), .lw_addr(lw_addr),
    .lw_data(lw_data), .lr_data(lr_data),
    .frame_done(frame_done), .frame_wr(frame_wr),
    .frame_err(frame_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (frame_done) begin
        dcnt++;
        last_wr = frame_wr;
      end
      if (frame_err) ecnt++;
    end
  endtask

  task automatic lwrite(input logic [4:0] a, input logic [23:0] d);
    lw_en = 1'b1; lw_addr = a; lw_data = d;
    tick(1);
    lw_en = 1'b0;
    ref_ram[a] = d;
  endtask

  task automatic lread(input logic [4:0] a);
    lw_addr = a;
    tick(1);
    chk("lr_data", {8'h0, lr_data}, {8'h0, ref_ram[a]});
  endtask

  // nbits < 32 aborts the frame (by csn or by reset when rst_mid)
  task automatic spi_frame(input logic [7:0] cmd, input logic [23:0] data,
                           input int nbits, input int extra,
                           input int half, input bit collide,
                           input bit rst_mid, output logic [23:0] rxd);
    bit rd;
    rd = !cmd[7];
    rxd = '0;
    dcnt = 0; ecnt = 0; last_wr = 1'bx;
    csn = 1'b0;
    tick(half);
    for (int i = 0; i < nbits; i++) begin
      si = (i < 8) ? cmd[7-i] : data[31-i];
      tick(half);
      if (i >= 8 && rd) begin
        rxd = {rxd[22:0], so};
        chk("so_oe_data", {31'h0, so_oe}, 32'h1);
      end else begin
        chk("so_oe_off", {31'h0, so_oe}, 32'h0);
      end
      sck = 1'b1;
      if (collide && i == 31) begin
        lw_en = 1'b1; lw_addr = cmd[4:0]; lw_data = 24'hFFFFFF;
      end
      for (int k = 0; k < half; k++) begin
        tick(1);
        if (collide && frame_done) lw_en = 1'b0;
      end
      lw_en = 1'b0;
      sck = 1'b0;
    end
    for (int e = 0; e < extra; e++) begin
      tick(half); sck = 1'b1;
      tick(half); sck = 1'b0;
    end
    if (rst_mid) begin
      rst = 1'b1;
      #1;
      chk("rst_so", {31'h0, so}, 32'h0);
      chk("rst_so_oe", {31'h0, so_oe}, 32'h0);
      chk("rst_flags", {29'h0, frame_done, frame_wr, frame_err}, 32'h0);
      csn = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(5);
    end else begin
      tick(half);
      csn = 1'b1;
      tick(5);
      chk("so_oe_end", {30'h0, so_oe, so}, 32'h0);
    end
  endtask

  initial begin
    logic [4:0]  a;
    logic [23:0] d;
    logic [1:0]  res;
    int          r, h, nb;
    rst = 1'b1; sck = 1'b0; csn = 1'b1; si = 1'b0;
    lw_en = 1'b0; lw_addr = '0; lw_data = '0;
    dcnt = 0; ecnt = 0; last_wr = 1'b0;
    #3;
    chk("reset_outs", {26'h0, so, so_oe, frame_done, frame_wr,
        frame_err, 1'b0}, 32'h0);
    tick(2);
    chk("reset_lr", {8'h0, lr_data}, 32'h0);
    rst = 1'b0;
    tick(5);
    for (int i = 0; i < 32; i++) lwrite(5'(i), 24'($urandom));

    // write frame
    spi_frame(8'h83, 24'hABCDEF, 32, 0, 4, 0, 0, rx);
    ref_ram[3] = 24'hABCDEF;
    chk("wr_done", dcnt, 1);
    chk("wr_flag", {31'h0, last_wr}, 32'h1);
    chk("wr_err", ecnt, 0);
    lread(3);

    // read frame
    lwrite(0, 24'hFEDCBA);
    spi_frame(8'h00, 24'h0, 32, 0, 4, 0, 0, rx);
    chk("rd_data", {8'h0, rx}, 32'h00FEDCBA);
    chk("rd_done", dcnt, 1);
    chk("rd_flag", {31'h0, last_wr}, 32'h0);

    // abort then full frame
    spi_frame(8'h85, 24'h5A5A5A, 18, 0, 4, 0, 0, rx);
    chk("ab_err", ecnt, 1);
    chk("ab_done", dcnt, 0);
    lread(5);
    spi_frame(8'h85, 24'h0F0F0F, 32, 0, 4, 0, 0, rx);
    ref_ram[5] = 24'h0F0F0F;
    chk("ab_next_done", dcnt, 1);
    chk("ab_next_err", ecnt, 0);
    lread(5);

    // reserved bits and extra clocks
    spi_frame(8'hE1, 24'h123456, 32, 4, 4, 0, 0, rx);
    ref_ram[1] = 24'h123456;
    chk("rsv_done", dcnt, 1);
    lread(1);

    // collision with local port
    spi_frame(8'h87, 24'h000111, 32, 0, 4, 1, 0, rx);
    ref_ram[7] = 24'h000111;
    chk("col_done", dcnt, 1);
    lread(7);

    // reset during read data
    spi_frame(8'h02, 24'h0, 13, 0, 4, 0, 1, rx);
    chk("rstm_done", dcnt, 0);
    chk("rstm_err", ecnt, 0);
    spi_frame(8'h02, 24'h0, 32, 0, 4, 0, 0, rx);
    chk("rstm_next", {8'h0, rx}, {8'h0, ref_ram[2]});
    chk("rstm_next_done", dcnt, 1);

    // randomized frames against the word-level model
    for (int n = 0; n < 30; n++) begin
      r   = $urandom_range(0, 9);
      a   = 5'($urandom);
      d   = 24'($urandom);
      res = 2'($urandom);
      h   = $urandom_range(3, 6);
      if (r < 4) begin
        spi_frame({1'b1, res, a}, d, 32, $urandom_range(0, 2), h,
                  0, 0, rx);
        ref_ram[a] = d;
        chk("rnd_wr_done", dcnt, 1);
        chk("rnd_wr_flag", {31'h0, last_wr}, 32'h1);
        lread(a);
      end else if (r < 8) begin
        spi_frame({1'b0, res, a}, d, 32, $urandom_range(0, 2), h,
                  0, 0, rx);
        chk("rnd_rd_data", {8'h0, rx}, {8'h0, ref_ram[a]});
        chk("rnd_rd_done", dcnt, 1);
        chk("rnd_rd_flag", {31'h0, last_wr}, 32'h0);
      end else begin
        nb = $urandom_range(1, 31);
        spi_frame({r[0], res, a}, d, nb, 0, h, 0, 0, rx);
        chk("rnd_ab_err", ecnt, 1);
        chk("rnd_ab_done", dcnt, 0);
        lread(a);
      end
      if ($urandom_range(0, 1) == 1) begin
        a = 5'($urandom);
        lwrite(a, 24'($urandom));
        lread(a);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_ram_responder.md
Name: spi_ram_responder

Overview:
SPI mode-0 responder that sits on the far end of the spi_master link and serves a 32 x 24-bit register RAM. The master sends an 8-bit command and then a 24-bit data phase; each frame is either a write into the RAM or a read from it. sck, csn and si are oversampled in the clk domain, so no logic runs on the sck clock. A local port lets the bench or SoC preload and inspect the RAM.

Parameters:
DATA_W, 24, RAM word width and data-phase length in bits
ADDR_W, 5, RAM address width (depth 2**ADDR_W = 32)
SYNC_STAGES, 2, synchroniser depth on sck/csn/si (minimum 2)

Ports:
clk  in  1  system clock; requires f_sck <= f_clk/6
rst  in  1  asynchronous, active-high reset
sck  in  1  SPI clock from master, idle low
csn  in  1  SPI chip select, active low
si  in  1  MOSI data
so  out  1  MISO data
so_oe  out  1  high while the responder drives so (read data phase only)
lw_en  in  1  local write strobe
lw_addr  in  ADDR_W  local write/read address
lw_data  in  DATA_W  local write data
lr_data  out  DATA_W  registered RAM[lw_addr], 1-cycle latency
frame_done  out  1  1-cycle pulse when a complete 32-bit frame ends
frame_wr  out  1  qualifies frame_done: 1 = write frame, 0 = read frame
frame_err  out  1  1-cycle pulse when csn rises mid-frame

Behaviour:
- Reset (async, active-high) clears the synchronisers, the shift registers, the bit counter and the state (to IDLE). Output values during reset: so=0, so_oe=0, lr_data=0, frame_done=0, frame_wr=0, frame_err=0. RAM contents are not reset.
- Edge detection:
  - sck_rise and sck_fall are derived from the last two synchronised sck samples.
  - csn_fall and csn_rise are derived the same way.
  - Only the synchronised si is sampled.
- Command byte, MSB first:
  - bit7 = R/W (1 = write).
  - bits6:5 reserved; they are ignored.
  - bits4:0 = address.
- States:
  - IDLE: csn_fall -> CMD; clear bit counter and shift registers.
  - CMD: on each sck_rise, shift si into cmd_sr and increment the counter. On the 8th rise, latch rw and addr, then:
    - write frame -> WDATA;
    - read frame -> capture RAM[addr] into tx_sr, preload so = tx_sr MSB on the next clk, assert so_oe, and go to RDATA.
  - WDATA: on each sck_rise, shift si into rx_sr. On the 24th rise, write RAM[addr] = rx_sr (full word), pulse frame_done with frame_wr=1, then -> DONE.
  - RDATA:
    - On each sck_fall, shift tx_sr left and drive the next bit on so; the master samples on the rising edge.
    - On the 24th sck_rise, pulse frame_done with frame_wr=0, then -> DONE.
    - Keep driving the LSB until csn rises.
  - DONE: ignore further sck edges (extra clocks are not counted). On csn_rise -> IDLE with so=0 and so_oe=0.
- csn_rise in CMD, WDATA or RDATA:
  - pulse frame_err;
  - no RAM write (a partial write is discarded);
  - so=0, so_oe=0, -> IDLE.
- csn_rise takes precedence over an sck edge detected in the same clk cycle.
- A csn_fall while not in IDLE cannot occur, because a csn_rise must come first; there is no back-to-back frame without csn high for at least 2 clk.
- Local port:
  - lw_en writes RAM[lw_addr]=lw_data on the clk edge.
  - lr_data = RAM[lw_addr] registered every cycle.
  - If the SPI commit and lw_en hit the same address in the same cycle, the SPI write wins and the local write is dropped.
  - A local write in the same cycle as a read-command capture of the same address: the capture takes the old value.
- Address wrap: not applicable. Every frame accesses exactly one word and all 5-bit addresses are valid.
- Reset mid-frame: the frame is aborted silently (no frame_err), the RAM is untouched, and the block restarts at IDLE.

Test Plan:
- Write frame: cmd 0x83, data 0xABCDEF, f_sck=f_clk/8 -> frame_done=1 with frame_wr=1; lr_data at lw_addr=3 reads 0xABCDEF.
- Read frame: preload RAM[0]=0xFEDCBA via lw, then cmd 0x00 plus 24 clocks -> master shift register holds 0xFEDCBA; so_oe high only during the 24 data bits; frame_wr=0.
- Abort: cmd 0x85 plus 10 data bits, then csn high -> frame_err pulse, no frame_done, RAM[5] unchanged; the next full frame completes normally.
- Reserved bits and extra clocks: cmd 0xE1, data 0x123456, then 4 extra sck -> RAM[1]=0x123456, exactly one frame_done.
- Collision: SPI commit to addr 7 (0x000111) in the same cycle as lw_en to addr 7 (0xFFFFFF) -> RAM[7]=0x000111.
- Async reset asserted mid-RDATA -> so=0, so_oe=0 and state IDLE in the same cycle, with no frame_done or frame_err; the following frame works.
